cajero_automatico_param: RTL and testbench
==========================================

CAJERO_AUTOMATICO_PARAM -- requirements
Module: cajero_automatico_param

Interface
REQ-001 SHALL have parameter PIN_DIGITS, 4, number of BCD digits in the PIN (2..8).
REQ-002 SHALL have parameter MAX_INTENTOS, 3, failed PIN attempts before lockout (2..15).
REQ-003 SHALL have parameter BALANCE_W, 64, balance width in bits.
REQ-004 SHALL have parameter MONTO_W, 32, amount width in bits (MONTO_W <= BALANCE_W).
REQ-005 SHALL have parameter TIMEOUT_CICLOS, 1000, inactivity limit (used only per REQ-030).
REQ-006 SHALL have port clock  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have ports tarjeta_recibida  input  1  card inserted; tipo_trans  input  1  0=deposit, 1=withdrawal.
REQ-009 SHALL have ports digito_stb  input  1  digit valid; digito  input  4  PIN digit.
REQ-010 SHALL have ports pin  input  4*PIN_DIGITS  stored PIN, MS digit in top nibble; balance_inicial  input  BALANCE_W  account balance.
REQ-011 SHALL have ports monto  input  MONTO_W  amount; monto_stb  input  1  amount valid.
REQ-012 SHALL have outputs balance_actualizado, entregar_dinero, pin_incorrecto, advertencia, bloqueo, fondos_insuficientes, each 1 bit, plus balance  output  BALANCE_W  current balance register.

Function
REQ-013 SHALL implement FSM states ESPERA_TARJETA, INGRESO_PIN, VERIFICAR, ESPERA_MONTO, PROCESAR, BLOQUEADO; all outputs registered.
REQ-014 ESPERA_TARJETA: tarjeta_recibida=1 -> latch balance_inicial into balance, clear digit count, next INGRESO_PIN.
REQ-015 INGRESO_PIN: each digito_stb=1 cycle shifts digito into PIN buffer LSB side (first digit ends in top nibble), count+1; when count reaches PIN_DIGITS -> VERIFICAR next cycle.
REQ-016 VERIFICAR (1 cycle): full-width compare with pin; match -> ESPERA_MONTO, attempt counter cleared, advertencia cleared.
REQ-017 Mismatch -> attempt counter+1, pin_incorrecto pulses 1 cycle, digit count cleared; counter == MAX_INTENTOS-1 -> advertencia set (level, until match or reset); counter == MAX_INTENTOS -> BLOQUEADO, else INGRESO_PIN.
REQ-018 ESPERA_MONTO: monto_stb=1 -> latch monto and tipo_trans, next PROCESAR.
REQ-019 PROCESAR deposit: balance += zero-extended monto, saturating at all-ones; balance_actualizado pulses 1 cycle; next ESPERA_TARJETA.
REQ-020 PROCESAR withdrawal, monto <= balance: balance -= monto; balance_actualizado and entregar_dinero pulse together 1 cycle; next ESPERA_TARJETA.
REQ-021 PROCESAR withdrawal, monto > balance: fondos_insuficientes pulses 1 cycle, balance unchanged, next ESPERA_TARJETA; monto == balance is a valid withdrawal giving 0.
REQ-022 BLOQUEADO: bloqueo=1 held; all inputs ignored; exit only via reset.
REQ-023 Strobes/card outside their owning state SHALL be ignored; digito values 10..15 accepted raw and compared as-is.
REQ-024 Pulse outputs SHALL be high exactly one cycle, the cycle after the deciding state.

Reset
REQ-025 reset=0 at a clock edge SHALL force ESPERA_TARJETA from any state, including mid-PIN and mid-PROCESAR.
REQ-026 Reset values: all 1-bit outputs 0, balance 0, attempt counter 0, digit count 0, PIN buffer 0, timeout counter 0.
REQ-027 Attempt counter and bloqueo SHALL clear only on reset (or correct PIN for counter), not on new card.

Configuration
REQ-028 Macro CAJERO_TIMEOUT_EN SHALL compile the inactivity timeout in or out.
REQ-029 Without it: INGRESO_PIN and ESPERA_MONTO wait indefinitely; no timeout counter exists.
REQ-030 With it: counter resets on entry and on each accepted strobe; reaching TIMEOUT_CICLOS in either state -> ESPERA_TARJETA, no output pulse, attempt counter preserved.

Structure
REQ-031 Package cajero_pkg SHALL hold the state encoding typedef and default parameter constants.
REQ-032 Sub-module cajero_pin_buffer SHALL hold the PIN shift register, digit counter and full flag.

Verification
REQ-033 pin=16'h1234, balance_inicial=500, digits 1,2,3,4, withdraw monto=200 -> entregar_dinero+balance_actualizado pulse, balance=300.
REQ-034 Three wrong PINs (MAX_INTENTOS=3) -> pin_incorrecto pulses x3, advertencia after 2nd, bloqueo=1 after 3rd, card ignored until reset.
REQ-035 balance_inicial=100, withdraw monto=101 -> fondos_insuficientes pulse, balance=100; monto=100 -> balance=0.
REQ-036 BALANCE_W=32, balance 32'hFFFF_FFF0, deposit 32 -> balance=32'hFFFF_FFFF.
REQ-037 reset=0 after 2 of 4 digits -> ESPERA_TARJETA, all outputs 0; new card with correct PIN succeeds.
REQ-038 CAJERO_TIMEOUT_EN, TIMEOUT_CICLOS=10, no digits for 10 cycles -> ESPERA_TARJETA, no pulses.

Source files
------------

// File: rtl/cajero_pkg.sv
// Purpose: shared state encoding and default parameters for the ATM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cajero_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA = 3'd0,
        INGRESO_PIN    = 3'd1,
        VERIFICAR      = 3'd2,
        ESPERA_MONTO   = 3'd3,
        PROCESAR       = 3'd4,
        BLOQUEADO      = 3'd5
    } estado_t;

    localparam int unsigned DEF_PIN_DIGITS     = 4;
    localparam int unsigned DEF_MAX_INTENTOS   = 3;
    localparam int unsigned DEF_BALANCE_W      = 64;
    localparam int unsigned DEF_MONTO_W        = 32;
    localparam int unsigned DEF_TIMEOUT_CICLOS = 1000;

endpackage

// File: rtl/cajero_pin_buffer.sv
// Purpose: PIN digit shift register with digit counter and full flag.
// Latency: a digit is visible in pin_buf and counted one cycle after its strobe.
// Backpressure: none; strobes arriving while full are dropped.
module cajero_pin_buffer
    import cajero_pkg::*;
#(
    parameter int unsigned PIN_DIGITS = DEF_PIN_DIGITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    shift,
    input  logic [3:0]              digito,
    output logic [4*PIN_DIGITS-1:0] pin_buf,
    output logic                    full
);

    localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);

    logic [CNT_W-1:0] cnt;

    assign full = (cnt == CNT_W'(PIN_DIGITS));

    // Shift new digits in at the LSB end so the first digit ends up in the top nibble.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pin_buf <= '0;
            cnt     <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift && !full) begin
            pin_buf <= {pin_buf[4*PIN_DIGITS-5:0], digito};
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cajero_automatico_param.sv
// Purpose: ATM session controller (card, PIN check with lockout, deposit/withdrawal); optional inactivity timeout under CAJERO_TIMEOUT_EN.
// Latency: every output is registered; pulses appear the cycle after the deciding state.
// Backpressure: none; strobes and card outside their owning state are ignored.
module cajero_automatico_param
    import cajero_pkg::*;
#(
    parameter int unsigned PIN_DIGITS     = DEF_PIN_DIGITS,
    parameter int unsigned MAX_INTENTOS   = DEF_MAX_INTENTOS,
    parameter int unsigned BALANCE_W      = DEF_BALANCE_W,
    parameter int unsigned MONTO_W        = DEF_MONTO_W,
    parameter int unsigned TIMEOUT_CICLOS = DEF_TIMEOUT_CICLOS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic                    tipo_trans,
    input  logic                    digito_stb,
    input  logic [3:0]              digito,
    input  logic [4*PIN_DIGITS-1:0] pin,
    input  logic [BALANCE_W-1:0]    balance_inicial,
    input  logic [MONTO_W-1:0]      monto,
    input  logic                    monto_stb,
    output logic                    balance_actualizado,
    output logic                    entregar_dinero,
    output logic                    pin_incorrecto,
    output logic                    advertencia,
    output logic                    bloqueo,
    output logic                    fondos_insuficientes,
    output logic [BALANCE_W-1:0]    balance
);

    estado_t                 estado, estado_sig;
    logic [3:0]              intentos, intentos_sig, intentos_inc;
    logic [MONTO_W-1:0]      monto_q;
    logic                    tipo_q;
    logic [BALANCE_W-1:0]    balance_sig, monto_ext;
    logic [BALANCE_W:0]      suma;
    logic                    pin_shift, pin_clr, latch_monto, timeout;
    logic                    ba_sig, ed_sig, pi_sig, fi_sig, adv_sig;
    logic [4*PIN_DIGITS-1:0] pin_buf;
    logic                    pin_full;

    cajero_pin_buffer #(.PIN_DIGITS(PIN_DIGITS)) u_pin_buffer (
        .clock   (clock),
        .reset   (reset),
        .clr     (pin_clr),
        .shift   (pin_shift),
        .digito  (digito),
        .pin_buf (pin_buf),
        .full    (pin_full)
    );

    assign monto_ext    = BALANCE_W'(monto_q);
    assign suma         = {1'b0, balance} + {1'b0, monto_ext};
    assign intentos_inc = intentos + 4'd1;

`ifdef CAJERO_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [TO_W-1:0] to_cnt;
    logic            stb_aceptado;

    assign stb_aceptado = (estado == INGRESO_PIN  && digito_stb && !pin_full) ||
                          (estado == ESPERA_MONTO && monto_stb);
    assign timeout      = (to_cnt == TO_W'(TIMEOUT_CICLOS - 1));

    // Inactivity counter: restarts on state change or accepted strobe, runs only while waiting for input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (estado_sig != estado || stb_aceptado) begin
            to_cnt <= '0;
        end else if (estado == INGRESO_PIN || estado == ESPERA_MONTO) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and next-output decode; pulses default low, levels hold.
    always_comb begin
        estado_sig   = estado;
        intentos_sig = intentos;
        balance_sig  = balance;
        adv_sig      = advertencia;
        pin_shift    = 1'b0;
        pin_clr      = 1'b0;
        latch_monto  = 1'b0;
        ba_sig       = 1'b0;
        ed_sig       = 1'b0;
        pi_sig       = 1'b0;
        fi_sig       = 1'b0;
        case (estado)
            ESPERA_TARJETA: begin
                if (tarjeta_recibida) begin
                    balance_sig = balance_inicial;
                    pin_clr     = 1'b1;
                    estado_sig  = INGRESO_PIN;
                end
            end
            INGRESO_PIN: begin
                if (pin_full) begin
                    estado_sig = VERIFICAR;
                end else if (digito_stb) begin
                    pin_shift = 1'b1;
                end else if (timeout) begin
                    estado_sig = ESPERA_TARJETA;
                end
            end
            VERIFICAR: begin
                if (pin_buf == pin) begin
                    intentos_sig = '0;
                    adv_sig      = 1'b0;
                    estado_sig   = ESPERA_MONTO;
                end else begin
                    intentos_sig = intentos_inc;
                    pi_sig       = 1'b1;
                    pin_clr      = 1'b1;
                    if (intentos_inc == 4'(MAX_INTENTOS - 1)) begin
                        adv_sig = 1'b1;
                    end
                    estado_sig = (intentos_inc == 4'(MAX_INTENTOS)) ? BLOQUEADO : INGRESO_PIN;
                end
            end
            ESPERA_MONTO: begin
                if (monto_stb) begin
                    latch_monto = 1'b1;
                    estado_sig  = PROCESAR;
                end else if (timeout) begin
                    estado_sig = ESPERA_TARJETA;
                end
            end
            PROCESAR: begin
                estado_sig = ESPERA_TARJETA;
                if (!tipo_q) begin
                    balance_sig = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
                    ba_sig      = 1'b1;
                end else if (monto_ext <= balance) begin
                    balance_sig = balance - monto_ext;
                    ba_sig      = 1'b1;
                    ed_sig      = 1'b1;
                end else begin
                    fi_sig = 1'b1;
                end
            end
            BLOQUEADO: begin
                estado_sig = BLOQUEADO;
            end
            default: begin
                estado_sig = ESPERA_TARJETA;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado               <= ESPERA_TARJETA;
            intentos             <= '0;
            monto_q              <= '0;
            tipo_q               <= 1'b0;
            balance              <= '0;
            balance_actualizado  <= 1'b0;
            entregar_dinero      <= 1'b0;
            pin_incorrecto       <= 1'b0;
            advertencia          <= 1'b0;
            bloqueo              <= 1'b0;
            fondos_insuficientes <= 1'b0;
        end else begin
            estado               <= estado_sig;
            intentos             <= intentos_sig;
            balance              <= balance_sig;
            balance_actualizado  <= ba_sig;
            entregar_dinero      <= ed_sig;
            pin_incorrecto       <= pi_sig;
            advertencia          <= adv_sig;
            bloqueo              <= (estado_sig == BLOQUEADO);
            fondos_insuficientes <= fi_sig;
            if (latch_monto) begin
                monto_q <= monto;
                tipo_q  <= tipo_trans;
            end
        end
    end

endmodule

// File: tb/tb_cajero_automatico_param.sv
module tb_cajero_automatico_param;

    localparam int PD = 4;
    localparam int MI = 3;
    localparam int BW = 32;
    localparam int MW = 32;
    localparam int TO = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tarjeta_recibida = 1'b0;
    logic          tipo_trans = 1'b0;
    logic          digito_stb = 1'b0;
    logic [3:0]    digito = '0;
    logic [4*PD-1:0] pin = 16'h1234;
    logic [BW-1:0] balance_inicial = '0;
    logic [MW-1:0] monto = '0;
    logic          monto_stb = 1'b0;
    logic          balance_actualizado, entregar_dinero, pin_incorrecto;
    logic          advertencia, bloqueo, fondos_insuficientes;
    logic [BW-1:0] balance;

    cajero_automatico_param #(
        .PIN_DIGITS(PD), .MAX_INTENTOS(MI), .BALANCE_W(BW),
        .MONTO_W(MW), .TIMEOUT_CICLOS(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans),
        .digito_stb(digito_stb), .digito(digito),
        .pin(pin), .balance_inicial(balance_inicial),
        .monto(monto), .monto_stb(monto_stb),
        .balance_actualizado(balance_actualizado), .entregar_dinero(entregar_dinero),
        .pin_incorrecto(pin_incorrecto), .advertencia(advertencia),
        .bloqueo(bloqueo), .fondos_insuficientes(fondos_insuficientes),
        .balance(balance)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: session phase 0=idle, 1=PIN entry, 2=amount, 3=locked.
    int            m_phase;
    int            m_int;
    logic [BW-1:0] m_bal;
    bit            m_adv;
    bit            m_lock;

    int c_pi, c_ba, c_ed, c_fi;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        c_pi = 0; c_ba = 0; c_ed = 0; c_fi = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        c_pi += int'(pin_incorrecto);
        c_ba += int'(balance_actualizado);
        c_ed += int'(entregar_dinero);
        c_fi += int'(fondos_insuficientes);
    endtask

    task automatic model_reset();
        m_phase = 0; m_int = 0; m_bal = '0; m_adv = 0; m_lock = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, {58'd0, balance_actualizado, entregar_dinero, pin_incorrecto,
                              advertencia, bloqueo, fondos_insuficientes}, 64'd0);
        chk({tag, "_balance"}, 64'(balance), 64'd0);
    endtask

    task automatic do_reset();
        tarjeta_recibida = 0; digito_stb = 0; monto_stb = 0;
        reset = 0;
        tick();
        tick();
        reset = 1;
        model_reset();
        check_all_zero("reset");
    endtask

    task automatic do_card(input logic [BW-1:0] bal);
        clr_counts();
        tarjeta_recibida = 1; balance_inicial = bal;
        tick();
        tarjeta_recibida = 0;
        tick();
        if (m_phase == 0) begin
            m_bal = bal;
            m_phase = 1;
        end
        chk("card_balance", 64'(balance), 64'(m_bal));
        chk("card_bloqueo", 64'(bloqueo), 64'(m_lock));
    endtask

    task automatic do_pin(input logic [4*PD-1:0] digs);
        int exp_pi;
        clr_counts();
        for (int i = 0; i < PD; i++) begin
            digito_stb = 1;
            digito = digs[4*PD-1-4*i -: 4];
            tick();
        end
        digito_stb = 0;
        repeat (5) tick();
        exp_pi = 0;
        if (m_phase == 1) begin
            if (digs == pin) begin
                m_phase = 2; m_int = 0; m_adv = 0;
            end else begin
                m_int++;
                exp_pi = 1;
                if (m_int == MI - 1) m_adv = 1;
                if (m_int == MI) begin
                    m_phase = 3; m_lock = 1;
                end
            end
        end
        chk("pin_incorrecto_pulses", 64'(c_pi), 64'(exp_pi));
        chk("advertencia", 64'(advertencia), 64'(m_adv));
        chk("bloqueo", 64'(bloqueo), 64'(m_lock));
    endtask

    task automatic do_monto(input bit tipo, input logic [MW-1:0] m);
        int e_ba, e_ed, e_fi;
        logic [63:0] sum;
        clr_counts();
        monto_stb = 1; tipo_trans = tipo; monto = m;
        tick();
        monto_stb = 0;
        repeat (4) tick();
        e_ba = 0; e_ed = 0; e_fi = 0;
        if (m_phase == 2) begin
            m_phase = 0;
            if (!tipo) begin
                sum = 64'(m_bal) + 64'(m);
                m_bal = (sum > 64'({BW{1'b1}})) ? {BW{1'b1}} : sum[BW-1:0];
                e_ba = 1;
            end else if (64'(m) <= 64'(m_bal)) begin
                m_bal = m_bal - BW'(m);
                e_ba = 1; e_ed = 1;
            end else begin
                e_fi = 1;
            end
        end
        chk("balance_actualizado_pulses", 64'(c_ba), 64'(e_ba));
        chk("entregar_dinero_pulses", 64'(c_ed), 64'(e_ed));
        chk("fondos_insuficientes_pulses", 64'(c_fi), 64'(e_fi));
        chk("balance_after_monto", 64'(balance), 64'(m_bal));
    endtask

    task automatic do_idle(input int n);
        clr_counts();
        repeat (n) tick();
`ifdef CAJERO_TIMEOUT_EN
        if ((m_phase == 1 || m_phase == 2) && n >= TO) m_phase = 0;
`endif
        chk("idle_pulses", 64'(c_pi + c_ba + c_ed + c_fi), 64'd0);
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        do_reset();

        // Nominal withdrawal.
        do_card(32'd500);
        do_pin(16'h1234);
        do_monto(1'b1, 32'd200);
        chk("withdraw_200_of_500", 64'(balance), 64'd300);

        // Insufficient funds, then exact-balance withdrawal.
        do_card(32'd100);
        do_pin(16'h1234);
        do_monto(1'b1, 32'd101);
        chk("overdraw_keeps_100", 64'(balance), 64'd100);
        do_card(32'd100);
        do_pin(16'h1234);
        do_monto(1'b1, 32'd100);
        chk("exact_withdraw_to_0", 64'(balance), 64'd0);

        // Saturating deposit.
        do_card(32'hFFFF_FFF0);
        do_pin(16'h1234);
        do_monto(1'b0, 32'd32);
        chk("deposit_saturates", 64'(balance), 64'hFFFF_FFFF);

        // Non-decimal digits compared raw.
        pin = 16'hAF0C;
        do_card(32'd7);
        do_pin(16'hAF0C);
        do_monto(1'b0, 32'd5);
        pin = 16'h1234;

        // Amount strobe while idle is ignored.
        do_monto(1'b0, 32'd50);

        // Reset in the middle of PIN entry.
        do_card(32'd42);
        digito_stb = 1; digito = 4'd1; tick();
        digito = 4'd2; tick();
        digito_stb = 0;
        reset = 0;
        tick();
        reset = 1;
        model_reset();
        check_all_zero("midpin_reset");
        do_card(32'd42);
        do_pin(16'h1234);
        do_monto(1'b1, 32'd2);

        // Long idle during PIN entry (times out only when the feature is built in).
        do_card(32'd1000);
        do_idle(15);
        do_card(32'd77);
        do_pin(16'h1234);
        do_monto(1'b0, 32'd3);

        // Lockout after three wrong PINs; card, PIN and amount then ignored.
        do_card(32'd300);
        do_pin(16'h1111);
        do_pin(16'h2222);
        do_pin(16'h3333);
        chk("locked_after_3", 64'(bloqueo), 64'd1);
        do_card(32'd900);
        do_pin(16'h1234);
        do_monto(1'b1, 32'd10);
        chk("locked_balance_kept", 64'(balance), 64'd300);
        do_reset();

        // Randomized sessions against the model.
        for (int k = 0; k < 60; k++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                do_card(($urandom_range(0, 1) == 1) ? BW'($urandom) : BW'($urandom_range(0, 1000)));
            end else if (op <= 5) begin
                do_pin(($urandom_range(0, 9) < 6) ? pin : 16'($urandom));
            end else if (op <= 8) begin
                do_monto(1'($urandom_range(0, 1)),
                         ($urandom_range(0, 1) == 1) ? MW'($urandom) : MW'($urandom_range(0, 1200)));
            end else if (m_lock) begin
                do_reset();
            end else begin
                do_idle(3);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
